// File: rtl/aes_round_key_arbiter.sv
// Round-key arbiter: shares one round-key store between the AES
// encryption and decryption cores with round-robin tie breaking.
module aes_round_key_arbiter #(
    parameter int NO_ROWS   = 4,
    parameter int NO_COLS   = 4,
    parameter int NO_ROUNDS = 10
) (
    input  logic                                 aes_clk,
    input  logic                                 resetn,
    input  logic                                 enc_key_req_i,
    input  logic [3:0]                           enc_key_sel_i,
    output logic                                 enc_key_vld_o,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] enc_cipher_key_o,
    input  logic                                 dec_key_req_i,
    input  logic [3:0]                           dec_key_sel_i,
    output logic                                 dec_key_vld_o,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] dec_cipher_key_o,
    output logic                                 ks_req_o,
    output logic [3:0]                           ks_sel_o,
    input  logic                                 ks_vld_i,
    input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] ks_key_i,
    output logic [1:0]                           grant_o,
    output logic                                 busy_o,
    output logic                                 sel_err_o
);

    localparam logic [3:0] MAX_SEL = 4'(NO_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } state_t;

    state_t     state;
    logic       owner_dec;
    logic       last_dec;
    logic       abort_q;

    logic       pick_enc;
    logic       pick_dec;
    logic [3:0] pick_sel;
    logic       own_req;
    logic [3:0] own_sel;
    logic       own_hold;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_enc = enc_key_req_i & (~dec_key_req_i | last_dec);
        pick_dec = dec_key_req_i & (~enc_key_req_i | ~last_dec);
        pick_sel = pick_enc ? enc_key_sel_i : dec_key_sel_i;
        own_req  = owner_dec ? dec_key_req_i : enc_key_req_i;
        own_sel  = owner_dec ? dec_key_sel_i : enc_key_sel_i;
        own_hold = own_req & (own_sel == ks_sel_o);
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            owner_dec        <= 1'b0;
            last_dec         <= 1'b1;
            abort_q          <= 1'b0;
            ks_req_o         <= 1'b0;
            ks_sel_o         <= 4'd0;
            grant_o          <= 2'b00;
            sel_err_o        <= 1'b0;
            enc_key_vld_o    <= 1'b0;
            dec_key_vld_o    <= 1'b0;
            enc_cipher_key_o <= '0;
            dec_cipher_key_o <= '0;
        end else begin
            sel_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_enc | pick_dec) begin
                        last_dec <= pick_dec;
                        if (pick_sel > MAX_SEL) begin
                            sel_err_o <= 1'b1;
                        end else begin
                            owner_dec <= pick_dec;
                            ks_req_o  <= 1'b1;
                            ks_sel_o  <= pick_sel;
                            grant_o   <= {pick_dec, pick_enc};
                            abort_q   <= 1'b0;
                            state     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // A request withdrawn mid-fetch still gets its key, but no vld.
                    if (!own_hold)
                        abort_q <= 1'b1;
                    if (ks_vld_i) begin
                        ks_req_o <= 1'b0;
                        if (owner_dec)
                            dec_cipher_key_o <= ks_key_i;
                        else
                            enc_cipher_key_o <= ks_key_i;
                        if (own_hold && !abort_q) begin
                            state         <= RESP;
                            enc_key_vld_o <= ~owner_dec;
                            dec_key_vld_o <= owner_dec;
                        end else begin
                            state   <= IDLE;
                            grant_o <= 2'b00;
                        end
                    end
                end
                RESP: begin
                    if (!own_hold) begin
                        state         <= IDLE;
                        grant_o       <= 2'b00;
                        enc_key_vld_o <= 1'b0;
                        dec_key_vld_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_key_arbiter.sv
// Testbench for aes_round_key_arbiter: directed scenarios plus a
// randomized transaction loop checked against a transaction-level model.
module tb_aes_round_key_arbiter;

    typedef logic [3:0][3:0][7:0] key_t;

    logic       aes_clk = 1'b0;
    logic       resetn  = 1'b0;
    logic       enc_key_req_i = 1'b0;
    logic [3:0] enc_key_sel_i = 4'd0;
    logic       enc_key_vld_o;
    key_t       enc_cipher_key_o;
    logic       dec_key_req_i = 1'b0;
    logic [3:0] dec_key_sel_i = 4'd0;
    logic       dec_key_vld_o;
    key_t       dec_cipher_key_o;
    logic       ks_req_o;
    logic [3:0] ks_sel_o;
    logic       ks_vld_i = 1'b0;
    key_t       ks_key_i = '0;
    logic [1:0] grant_o;
    logic       busy_o;
    logic       sel_err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    key_t m_enc_key;
    key_t m_dec_key;
    bit   m_last_dec;

    aes_round_key_arbiter #(
        .NO_ROWS  (4),
        .NO_COLS  (4),
        .NO_ROUNDS(10)
    ) dut (
        .aes_clk         (aes_clk),
        .resetn          (resetn),
        .enc_key_req_i   (enc_key_req_i),
        .enc_key_sel_i   (enc_key_sel_i),
        .enc_key_vld_o   (enc_key_vld_o),
        .enc_cipher_key_o(enc_cipher_key_o),
        .dec_key_req_i   (dec_key_req_i),
        .dec_key_sel_i   (dec_key_sel_i),
        .dec_key_vld_o   (dec_key_vld_o),
        .dec_cipher_key_o(dec_cipher_key_o),
        .ks_req_o        (ks_req_o),
        .ks_sel_o        (ks_sel_o),
        .ks_vld_i        (ks_vld_i),
        .ks_key_i        (ks_key_i),
        .grant_o         (grant_o),
        .busy_o          (busy_o),
        .sel_err_o       (sel_err_o)
    );

    always #5 aes_clk = ~aes_clk;

    task automatic tick();
        @(posedge aes_clk);
        #1;
    endtask

    function automatic key_t rnd_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({enc_key_vld_o, dec_key_vld_o, ks_req_o, ks_sel_o, grant_o, busy_o, sel_err_o} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 0",
                {enc_key_vld_o, dec_key_vld_o, ks_req_o, ks_sel_o, grant_o, busy_o, sel_err_o});
        end
        tests_run++;
        if ({enc_cipher_key_o, dec_cipher_key_o} !== 256'd0) begin
            tests_failed++;
            $display("FAIL reset_keys: got %h %h required 0", enc_cipher_key_o, dec_cipher_key_o);
        end
        m_enc_key  = '0;
        m_dec_key  = '0;
        m_last_dec = 1'b1;
        resetn = 1'b1;
    endtask

    task automatic test_tie();
        key_t k1 = rnd_key();
        key_t k2 = rnd_key();
        key_t k3 = rnd_key();
        enc_key_req_i = 1'b1; enc_key_sel_i = 4'd3;
        dec_key_req_i = 1'b1; dec_key_sel_i = 4'd10;
        tick();
        tests_run++;
        if ({grant_o, ks_req_o, ks_sel_o} !== {2'b01, 1'b1, 4'd3}) begin
            tests_failed++;
            $display("FAIL tie1_grant: got %b/%b/%0d required 01/1/3", grant_o, ks_req_o, ks_sel_o);
        end
        ks_vld_i = 1'b1; ks_key_i = k1;
        tick();
        ks_vld_i = 1'b0;
        m_enc_key = k1;
        tests_run++;
        if ({enc_key_vld_o, dec_key_vld_o, enc_cipher_key_o} !== {2'b10, m_enc_key}) begin
            tests_failed++;
            $display("FAIL tie1_resp: got vld %b%b key %h required 10 %h",
                enc_key_vld_o, dec_key_vld_o, enc_cipher_key_o, m_enc_key);
        end
        enc_key_req_i = 1'b0;
        tick();
        enc_key_req_i = 1'b1; enc_key_sel_i = 4'd5;
        tick();
        tests_run++;
        if ({grant_o, ks_req_o, ks_sel_o} !== {2'b10, 1'b1, 4'd10}) begin
            tests_failed++;
            $display("FAIL tie2_grant: got %b/%b/%0d required 10/1/10", grant_o, ks_req_o, ks_sel_o);
        end
        ks_vld_i = 1'b1; ks_key_i = k2;
        tick();
        ks_vld_i = 1'b0;
        m_dec_key = k2;
        tests_run++;
        if ({enc_key_vld_o, dec_key_vld_o, dec_cipher_key_o, enc_cipher_key_o} !== {2'b01, m_dec_key, m_enc_key}) begin
            tests_failed++;
            $display("FAIL tie2_resp: got vld %b%b dec %h enc %h", enc_key_vld_o, dec_key_vld_o,
                dec_cipher_key_o, enc_cipher_key_o);
        end
        dec_key_req_i = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({grant_o, ks_sel_o} !== {2'b01, 4'd5}) begin
            tests_failed++;
            $display("FAIL pending_enc: got %b/%0d required 01/5", grant_o, ks_sel_o);
        end
        ks_vld_i = 1'b1; ks_key_i = k3;
        tick();
        ks_vld_i = 1'b0;
        m_enc_key = k3;
        tests_run++;
        if ({enc_key_vld_o, enc_cipher_key_o} !== {1'b1, m_enc_key}) begin
            tests_failed++;
            $display("FAIL pending_resp: got %b %h required 1 %h", enc_key_vld_o, enc_cipher_key_o, m_enc_key);
        end
        enc_key_req_i = 1'b0;
        tick();
        m_last_dec = 1'b0;
    endtask

    task automatic test_basic();
        key_t k = rnd_key();
        enc_key_req_i = 1'b1; enc_key_sel_i = 4'd0;
        tick();
        tests_run++;
        if ({ks_req_o, ks_sel_o, grant_o, busy_o, enc_key_vld_o} !== {1'b1, 4'd0, 2'b01, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_edge1: got %b/%0d/%b/%b/%b", ks_req_o, ks_sel_o, grant_o, busy_o, enc_key_vld_o);
        end
        ks_vld_i = 1'b1; ks_key_i = k;
        tick();
        ks_vld_i = 1'b0;
        m_enc_key = k;
        tests_run++;
        if ({enc_key_vld_o, ks_req_o, enc_cipher_key_o} !== {1'b1, 1'b0, m_enc_key}) begin
            tests_failed++;
            $display("FAIL basic_edge2: got vld %b req %b key %h required 1 0 %h",
                enc_key_vld_o, ks_req_o, enc_cipher_key_o, m_enc_key);
        end
        tick();
        tests_run++;
        if ({enc_key_vld_o, busy_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL basic_hold: got %b%b required 11", enc_key_vld_o, busy_o);
        end
        enc_key_req_i = 1'b0;
        tick();
        tests_run++;
        if ({enc_key_vld_o, busy_o, grant_o, enc_cipher_key_o} !== {4'b0000, m_enc_key}) begin
            tests_failed++;
            $display("FAIL basic_release: got %b%b%b key %h", enc_key_vld_o, busy_o, grant_o, enc_cipher_key_o);
        end
        m_last_dec = 1'b0;
    endtask

    task automatic test_store_delay();
        key_t k = rnd_key();
        dec_key_req_i = 1'b1; dec_key_sel_i = 4'd10;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({ks_req_o, ks_sel_o, dec_key_vld_o} !== {1'b1, 4'd10, 1'b0}) begin
                tests_failed++;
                $display("FAIL delay_wait%0d: got %b/%0d/%b required 1/10/0", i, ks_req_o, ks_sel_o, dec_key_vld_o);
            end
            tick();
        end
        ks_vld_i = 1'b1; ks_key_i = k;
        tick();
        ks_vld_i = 1'b0;
        m_dec_key = k;
        tests_run++;
        if ({dec_key_vld_o, ks_req_o, dec_cipher_key_o} !== {2'b10, m_dec_key}) begin
            tests_failed++;
            $display("FAIL delay_resp: got %b%b %h required 10 %h", dec_key_vld_o, ks_req_o, dec_cipher_key_o, m_dec_key);
        end
        dec_key_req_i = 1'b0;
        tick();
        m_last_dec = 1'b1;
    endtask

    task automatic test_sel_err();
        enc_key_req_i = 1'b1; enc_key_sel_i = 4'd11;
        tick();
        enc_key_req_i = 1'b0;
        tests_run++;
        if ({sel_err_o, ks_req_o, busy_o, grant_o} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL err_pulse: got %b%b%b%b required 10000", sel_err_o, ks_req_o, busy_o, grant_o);
        end
        tick();
        tests_run++;
        if ({sel_err_o, ks_req_o, busy_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL err_clear: got %b%b%b required 000", sel_err_o, ks_req_o, busy_o);
        end
        m_last_dec = 1'b0;
    endtask

    task automatic test_drop_fetch();
        key_t k1 = rnd_key();
        key_t k2 = rnd_key();
        enc_key_req_i = 1'b1; enc_key_sel_i = 4'd2;
        tick();
        enc_key_req_i = 1'b0;
        dec_key_req_i = 1'b1; dec_key_sel_i = 4'd7;
        tick();
        tests_run++;
        if ({ks_req_o, ks_sel_o, grant_o} !== {1'b1, 4'd2, 2'b01}) begin
            tests_failed++;
            $display("FAIL drop_fetch: got %b/%0d/%b required 1/2/01", ks_req_o, ks_sel_o, grant_o);
        end
        ks_vld_i = 1'b1; ks_key_i = k1;
        tick();
        ks_vld_i = 1'b0;
        m_enc_key = k1;
        tests_run++;
        if ({enc_key_vld_o, busy_o, enc_cipher_key_o} !== {2'b00, m_enc_key}) begin
            tests_failed++;
            $display("FAIL drop_capture: got vld %b busy %b key %h required 0 0 %h",
                enc_key_vld_o, busy_o, enc_cipher_key_o, m_enc_key);
        end
        tick();
        tests_run++;
        if ({grant_o, ks_req_o, ks_sel_o} !== {2'b10, 1'b1, 4'd7}) begin
            tests_failed++;
            $display("FAIL drop_next: got %b/%b/%0d required 10/1/7", grant_o, ks_req_o, ks_sel_o);
        end
        ks_vld_i = 1'b1; ks_key_i = k2;
        tick();
        ks_vld_i = 1'b0;
        m_dec_key = k2;
        tests_run++;
        if ({dec_key_vld_o, dec_cipher_key_o, enc_cipher_key_o} !== {1'b1, m_dec_key, m_enc_key}) begin
            tests_failed++;
            $display("FAIL drop_next_resp: got %b %h %h", dec_key_vld_o, dec_cipher_key_o, enc_cipher_key_o);
        end
        dec_key_req_i = 1'b0;
        tick();
        m_last_dec = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        m_enc_key = '0; m_dec_key = '0; m_last_dec = 1'b1;
        tick();
        dec_key_req_i = 1'b1; dec_key_sel_i = 4'd4;
        tick();
        tests_run++;
        if ({ks_req_o, ks_sel_o} !== {1'b1, 4'd4}) begin
            tests_failed++;
            $display("FAIL rst_fetch_start: got %b/%0d required 1/4", ks_req_o, ks_sel_o);
        end
        tick();
        #2;
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({ks_req_o, ks_sel_o, grant_o, busy_o, enc_key_vld_o, dec_key_vld_o, sel_err_o} !== 11'd0) begin
            tests_failed++;
            $display("FAIL rst_async: got %b/%0d/%b/%b/%b/%b/%b", ks_req_o, ks_sel_o, grant_o, busy_o,
                enc_key_vld_o, dec_key_vld_o, sel_err_o);
        end
        ks_vld_i = 1'b1; ks_key_i = rnd_key();
        tick();
        tests_run++;
        if ({enc_cipher_key_o, dec_cipher_key_o} !== {m_enc_key, m_dec_key}) begin
            tests_failed++;
            $display("FAIL rst_no_capture: got %h %h required 0", enc_cipher_key_o, dec_cipher_key_o);
        end
        ks_vld_i = 1'b0;
        dec_key_req_i = 1'b0;
        resetn = 1'b1;
        tick();
        tests_run++;
        if ({busy_o, ks_req_o, dec_key_vld_o, dec_cipher_key_o} !== {3'b000, m_dec_key}) begin
            tests_failed++;
            $display("FAIL rst_after: got %b%b%b %h", busy_o, ks_req_o, dec_key_vld_o, dec_cipher_key_o);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            int unsigned pat = $urandom_range(3, 1);
            logic [3:0] es = 4'($urandom_range(11, 0));
            logic [3:0] ds = 4'($urandom_range(11, 0));
            bit w_dec;
            logic [3:0] wsel;
            bit drop = ($urandom_range(3, 0) == 0);
            int d = $urandom_range(3, 0);
            key_t k = rnd_key();
            if (pat == 3) w_dec = !m_last_dec;
            else          w_dec = (pat == 2);
            wsel = w_dec ? ds : es;
            enc_key_req_i = pat[0]; enc_key_sel_i = es;
            dec_key_req_i = pat[1]; dec_key_sel_i = ds;
            tick();
            m_last_dec = w_dec;
            if (wsel > 4'd10) begin
                tests_run++;
                if ({sel_err_o, ks_req_o, busy_o} !== 3'b100) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_err: got %b%b%b required 100", it, sel_err_o, ks_req_o, busy_o);
                end
                enc_key_req_i = 1'b0; dec_key_req_i = 1'b0;
                tick();
                continue;
            end
            tests_run++;
            if ({ks_req_o, ks_sel_o, grant_o, busy_o} !== {1'b1, wsel, w_dec, !w_dec, 1'b1}) begin
                tests_failed++;
                $display("FAIL rnd%0d_grant: got %b/%0d/%b/%b required 1/%0d/%b%b/1",
                    it, ks_req_o, ks_sel_o, grant_o, busy_o, wsel, w_dec, !w_dec);
            end
            if (w_dec) enc_key_req_i = 1'b0; else dec_key_req_i = 1'b0;
            if (drop) begin enc_key_req_i = 1'b0; dec_key_req_i = 1'b0; end
            for (int c = 0; c < d; c++) begin
                tick();
                tests_run++;
                if ({ks_req_o, ks_sel_o} !== {1'b1, wsel}) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_stable: got %b/%0d required 1/%0d", it, ks_req_o, ks_sel_o, wsel);
                end
            end
            ks_vld_i = 1'b1; ks_key_i = k;
            tick();
            ks_vld_i = 1'b0;
            if (w_dec) m_dec_key = k; else m_enc_key = k;
            tests_run++;
            if ({enc_key_vld_o, dec_key_vld_o, busy_o, enc_cipher_key_o, dec_cipher_key_o} !==
                {!drop && !w_dec, !drop && w_dec, !drop, m_enc_key, m_dec_key}) begin
                tests_failed++;
                $display("FAIL rnd%0d_resp: got vld %b%b busy %b enc %h dec %h drop %0d",
                    it, enc_key_vld_o, dec_key_vld_o, busy_o, enc_cipher_key_o, dec_cipher_key_o, drop);
            end
            enc_key_req_i = 1'b0; dec_key_req_i = 1'b0;
            tick();
            tests_run++;
            if ({enc_key_vld_o, dec_key_vld_o, busy_o, grant_o} !== 5'd0) begin
                tests_failed++;
                $display("FAIL rnd%0d_idle: got %b%b%b%b required 00000", it, enc_key_vld_o, dec_key_vld_o, busy_o, grant_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_basic();
        test_store_delay();
        test_sel_err();
        test_drop_fetch();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
